pc_fetch_ctrl: RTL and testbench

Program-counter and fetch-redirect controller that sits directly downstream of the branch unit and consumes its take decision. It holds the PC and loads the reset and interrupt vectors from instruction memory through a small FSM. It applies redirects on a taken branch or an interrupt entry, holds the PC on pipeline stalls, and generates the front-end flush pulse.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/pc_fetch_ctrl_flush_ctr.sv | 26 ++
 rtl/pc_fetch_ctrl.sv | 97 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-type codes, fetch defaults and the fetch FSM state encoding.
package cpu_pkg;

  localparam int DEF_PC_W           = 8;
  localparam int DEF_RESET_VEC_ADDR = 0;
  localparam int DEF_INT_VEC_ADDR   = 1;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_JMP  = 3'd5
  } br_type_e;

  typedef enum logic [1:0] {
    S_RST_VEC = 2'd0,
    S_RUN     = 2'd1,
    S_INT_VEC = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_flush_ctr.sv
// Loadable saturating down-counter; flush stays high while the count is non-zero.
module flush_ctr #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_flush
);

  logic [1:0] r_cnt;

  // A reload replaces the remaining count rather than adding to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
    end else if (i_load) begin
      r_cnt <= 2'(FLUSH_CYCLES);
    end else if (r_cnt != 2'd0) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  assign o_flush = (r_cnt != 2'd0);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch-redirect controller: vector loads, branch/interrupt redirects,
// stall hold and front-end flush generation.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int          PC_W           = DEF_PC_W,
  parameter int          RESET_VEC_ADDR = DEF_RESET_VEC_ADDR,
  parameter int          INT_VEC_ADDR   = DEF_INT_VEC_ADDR,
  parameter int unsigned FLUSH_CYCLES   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            b_take,
  input  logic [PC_W-1:0] b_target,
  input  logic            stall,
  input  logic            int_req,
  input  logic [PC_W-1:0] imem_data,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  output logic            fetch_valid,
  output logic            flush,
  output logic            int_ack,
  output logic [PC_W-1:0] ret_pc
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] r_ret_pc;
  logic [PC_W-1:0] w_ret_nxt;
  logic            w_load;
  logic            w_int_ack;
  logic            w_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RST_VEC;
      r_pc     <= PC_W'(RESET_VEC_ADDR);
      r_ret_pc <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ret_pc <= w_ret_nxt;
    end
  end

  // Priority in S_RUN: branch, then interrupt (only when not stalled), then stall, then increment.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ret_nxt   = r_ret_pc;
    w_load      = 1'b0;
    w_int_ack   = 1'b0;
    case (r_state)
      S_RST_VEC, S_INT_VEC: begin
        w_pc_nxt    = imem_data;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (b_take) begin
          w_pc_nxt = b_target;
          w_load   = 1'b1;
        end else if (int_req && !stall) begin
          w_ret_nxt   = r_pc;
          w_int_ack   = 1'b1;
          w_pc_nxt    = PC_W'(INT_VEC_ADDR);
          w_state_nxt = S_INT_VEC;
          w_load      = 1'b1;
        end else if (!stall) begin
          w_pc_nxt = r_pc + PC_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_RST_VEC;
        w_pc_nxt    = PC_W'(RESET_VEC_ADDR);
      end
    endcase
  end

  flush_ctr #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .o_flush(w_flush)
  );

  assign pc          = r_pc;
  assign pc_plus1    = r_pc + PC_W'(1);
  assign ret_pc      = r_ret_pc;
  assign flush       = w_flush;
  assign int_ack     = w_int_ack;
  assign fetch_valid = (r_state == S_RUN) && !stall && !w_flush;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a cycle table plus wrap and async-reset sequences.
module tb_pc_fetch_ctrl;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       b_take = 1'b0;
  logic [7:0] b_target = 8'h00;
  logic       stall = 1'b0;
  logic       int_req = 1'b0;
  logic [7:0] imem_data;
  logic [7:0] pc, pc_plus1, ret_pc;
  logic       fetch_valid, flush, int_ack;
  logic [7:0] mem [256];

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[pc];

  pc_fetch_ctrl #(
    .PC_W(8), .RESET_VEC_ADDR(0), .INT_VEC_ADDR(1), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .b_take(b_take), .b_target(b_target), .stall(stall),
    .int_req(int_req), .imem_data(imem_data), .pc(pc), .pc_plus1(pc_plus1),
    .fetch_valid(fetch_valid), .flush(flush), .int_ack(int_ack), .ret_pc(ret_pc)
  );

  typedef struct packed {
    logic       bt;
    logic [7:0] tgt;
    logic       st;
    logic       ir;
    logic [7:0] pc;
    logic       fv;
    logic       fl;
    logic       ack;
    logic [7:0] ret;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] epc, input logic efv,
                         input logic efl, input logic eack);
    chk({tag, " pc"}, 32'(pc), 32'(epc));
    chk({tag, " pc_plus1"}, 32'(pc_plus1), 32'(8'(epc + 8'd1)));
    chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'(efv));
    chk({tag, " flush"}, 32'(flush), 32'(efl));
    chk({tag, " int_ack"}, 32'(int_ack), 32'(eack));
  endtask

  // Asserts reset, checks the reset state, and releases it on a falling edge (cycle 0 begins).
  task automatic do_reset(input string tag);
    b_take = 1'b0; stall = 1'b0; int_req = 1'b0; b_target = 8'h00;
    rst_n = 1'b0;
    #1;
    chk_out({tag, " rst"}, 8'h00, 1'b0, 1'b0, 1'b0);
    chk({tag, " rst ret_pc"}, 32'(ret_pc), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] wrap_pc [5];
    logic       wrap_fv [5];

    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'h20;
    mem[1] = 8'h80;

    //            bt  tgt    st  ir   pc     fv  fl  ack ret
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h21, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h23, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h24, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h25, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[8]  = '{1'b1, 8'h99, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 8'h25};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 8'h25};
    tbl[10] = '{1'b1, 8'h2F, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0, 8'h25};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h2F, 1'b0, 1'b1, 1'b0, 8'h25};
    tbl[12] = '{1'b1, 8'h40, 1'b1, 1'b0, 8'h30, 1'b0, 1'b1, 1'b0, 8'h25};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 1'b0, 1'b1, 1'b0, 8'h25};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 1'b0, 1'b1, 1'b0, 8'h25};
    tbl[15] = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h42, 1'b1, 1'b0, 1'b0, 8'h25};
    tbl[16] = '{1'b1, 8'h50, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h25};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h50, 1'b0, 1'b1, 1'b1, 8'h25};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h50};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 8'h50};
    tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 8'h50};
    tbl[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0, 8'h50};

    #2;
    @(negedge clk);
    do_reset("tbl");
    for (int i = 0; i < 22; i++) begin
      b_take = tbl[i].bt; b_target = tbl[i].tgt; stall = tbl[i].st; int_req = tbl[i].ir;
      #1;
      chk_out($sformatf("row%0d", i), tbl[i].pc, tbl[i].fv, tbl[i].fl, tbl[i].ack);
      chk($sformatf("row%0d ret_pc", i), 32'(ret_pc), 32'(tbl[i].ret));
      @(negedge clk);
    end

    // PC wraps from 0xFF to 0x00 with no disturbance on flush or fetch_valid.
    mem[0] = 8'hFE;
    wrap_pc = '{8'h00, 8'hFE, 8'hFF, 8'h00, 8'h01};
    wrap_fv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset("wrap");
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_out($sformatf("wrap%0d", i), wrap_pc[i], wrap_fv[i], 1'b0, 1'b0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of an interrupt-vector fetch with flush active.
    mem[0] = 8'h20;
    do_reset("arst");
    #1;
    chk_out("arst c0", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    int_req = 1'b1;
    #1;
    chk_out("arst c1", 8'h20, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    int_req = 1'b0;
    #1;
    chk_out("arst intvec", 8'h01, 1'b0, 1'b1, 1'b0);
    chk("arst intvec ret_pc", 32'(ret_pc), 32'h20);
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("arst now", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("arst now ret_pc", 32'(ret_pc), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("arst again c0", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk_out("arst again c1", 8'h20, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
